scr1_imem_responder: RTL and testbench
======================================

// Module: scr1_imem_responder
// PURPOSE
//  Target-side endpoint of the SCR1 IMEM protocol: accepts fetch requests (req/req_ack), returns one
//  registered response per accepted request (imem_resp/imem_rdata) after a fixed wait-state count.
//  Holds a word-organised instruction RAM preloaded through a sideband load port. Attaches to a
//  router output port (e.g. port1) or directly to the core IMEM interface; also serves as a bench model.
// PARAMETERS
//  SCR1_MEM_BASE     `SCR1_IMEM_AWIDTH'h00010000  byte base address; must be aligned to SCR1_MEM_WORDS*4
//  SCR1_MEM_WORDS    1024                         RAM depth in 32-bit words; power of 2, 16..65536
//  SCR1_WAIT_STATES  1                            extra cycles between accept and response; 0..15
// PORTS
//  clk           in   1                   clock, all state on posedge
//  rst_n         in   1                   reset, asynchronous, active-low
//  imem_req_ack  out  1                   request accepted this cycle (when imem_req=1)
//  imem_req      in   1                   request valid
//  imem_cmd      in   1                   type_scr1_mem_cmd_e; only SCR1_MEM_CMD_RD is legal
//  imem_addr     in   SCR1_IMEM_AWIDTH    byte address of fetch
//  imem_rdata    out  SCR1_IMEM_DWIDTH    read data, valid only with RDY_OK
//  imem_resp     out  2                   type_scr1_mem_resp_e: IDLE / RDY_OK / RDY_ER
//  ld_en         in   1                   preload write strobe
//  ld_addr       in   SCR1_IMEM_AWIDTH    preload byte address (word-aligned, absolute)
//  ld_data       in   SCR1_IMEM_DWIDTH    preload data
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, cnt=0, imem_resp=SCR1_MEM_RESP_NOTRDY, imem_rdata=0,
//   imem_req_ack=0 (gated by rst_n). RAM contents not reset. Pending transaction dropped, no response.
//  Decode: AW=$clog2(SCR1_MEM_WORDS); idx=addr[AW+1:2]; in_range=(addr & ~(WORDS*4-1))==SCR1_MEM_BASE.
//  err = ~in_range | (imem_cmd!=SCR1_MEM_CMD_RD) | (addr[1:0]!=0).
//  FSM states IDLE, WAIT, RESP:
//   imem_req_ack = rst_n & ~ld_en & (state==IDLE | state==RESP); combinational, no dependency on imem_req.
//   accept = imem_req & imem_req_ack: latch idx_r, err_r; cnt<=WAIT_STATES;
//     next = (WAIT_STATES==0) ? RESP : WAIT.
//   IDLE: no accept -> stay.
//   WAIT: cnt decrements each cycle; when cnt==1 -> RESP (WAIT occupies exactly WAIT_STATES cycles).
//   RESP: imem_resp=RDY_ER if err_r else RDY_OK, for exactly one cycle; then accept -> WAIT/RESP
//     (back-to-back, new request overlaps response cycle) else -> IDLE.
//  Latency: request accepted at edge T -> response in cycle after edge T+WAIT_STATES (1 cycle min).
//  Throughput: WAIT_STATES=0 -> one response per cycle sustained; otherwise one per WAIT_STATES+1.
//  imem_resp = NOTRDY in IDLE and WAIT. imem_rdata is a register loaded on the edge entering RESP with
//   mem[idx_r] (RDY_OK) or 0 (RDY_ER); cleared to 0 on the edge leaving RESP without a new response.
//  Preload: ld_en=1 and ld_addr in range -> mem[ld_addr idx]<=ld_data at posedge; out-of-range or
//   misaligned ld_addr ignored silently. ld_en blocks new accepts only; an in-flight transaction
//   completes. Same-edge load and response read of one word: response returns the OLD word.
//  imem_addr/imem_cmd are don't-care when imem_req=0; X on them with imem_req=1 flagged by SVA (sim only).
//  No response without prior accept; exactly one response per accept (SVA in SCR1_TRGT_SIMULATION).
// TESTING
//  1 Reset: rst_n=0 -> ack=0, resp=NOTRDY, rdata=0; release with req=0 -> ack=1, resp stays NOTRDY.
//  2 WAIT_STATES=1: preload mem[0x0001_0010]=0xDEADBEEF, fetch 0x0001_0010 -> ack at T, resp=RDY_OK
//    with rdata=0xDEADBEEF in cycle T+2 only; ack=0 in WAIT cycle T+1.
//  3 Errors: fetch 0x0002_0000 (out of range), 0x0001_0002 (misaligned), cmd=WR at 0x0001_0000
//    -> each returns RDY_ER with rdata=0 after same latency; following legal fetch returns RDY_OK.
//  4 WAIT_STATES=0 streaming: req held high, addresses 0x0001_0000..0x0001_003C -> 16 consecutive
//    RDY_OK cycles, data in order, ack=1 every cycle.
//  5 Reset mid-op: WAIT_STATES=3, assert rst_n=0 in WAIT -> no response ever appears; post-reset fetch OK.
//  6 Loader: ld_en held 4 cycles -> ack=0 throughout; same-edge write/read of 0x0001_0020 returns old data.

Source files
------------

// File: rtl/scr1_imem_responder.sv
// SCR1 IMEM target endpoint: fixed-latency fetch responder
// backed by a word RAM preloaded through a sideband port.
`timescale 1ns/1ps

`ifndef SCR1_IMEM_AWIDTH
`define SCR1_IMEM_AWIDTH 32
`endif
`ifndef SCR1_IMEM_DWIDTH
`define SCR1_IMEM_DWIDTH 32
`endif

module scr1_imem_responder #(
  parameter logic [`SCR1_IMEM_AWIDTH-1:0] SCR1_MEM_BASE =
    `SCR1_IMEM_AWIDTH'h00010000,
  parameter int unsigned SCR1_MEM_WORDS   = 1024,
  parameter int unsigned SCR1_WAIT_STATES = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic                         imem_req_ack,
  input  logic                         imem_req,
  input  logic                         imem_cmd,
  input  logic [`SCR1_IMEM_AWIDTH-1:0] imem_addr,
  output logic [`SCR1_IMEM_DWIDTH-1:0] imem_rdata,
  output logic [1:0]                   imem_resp,
  input  logic                         ld_en,
  input  logic [`SCR1_IMEM_AWIDTH-1:0] ld_addr,
  input  logic [`SCR1_IMEM_DWIDTH-1:0] ld_data
);

  localparam int unsigned AWD = `SCR1_IMEM_AWIDTH;
  localparam int unsigned DWD = `SCR1_IMEM_DWIDTH;
  localparam int unsigned AW  = $clog2(SCR1_MEM_WORDS);

  localparam logic [AWD-1:0] SPAN = AWD'(SCR1_MEM_WORDS * 4);
  localparam logic [AWD-1:0] MASK = ~(SPAN - AWD'(1));

  localparam logic       CMD_RD      = 1'b0;
  localparam logic [1:0] RESP_NOTRDY = 2'b00;
  localparam logic [1:0] RESP_RDY_OK = 2'b01;
  localparam logic [1:0] RESP_RDY_ER = 2'b10;

  localparam logic [3:0] WS  = 4'(SCR1_WAIT_STATES);
  localparam bit         WS0 = (SCR1_WAIT_STATES == 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  state_e          state;
  state_e          state_nx;
  logic [3:0]      cnt;
  logic [AW-1:0]   idx_r;
  logic            err_r;
  logic [AW-1:0]   req_idx;
  logic            req_err;
  logic [AW-1:0]   rsp_idx;
  logic            rsp_err;
  logic            accept;
  logic            ld_ok;
  logic [DWD-1:0]  mem [SCR1_MEM_WORDS];

  function automatic logic in_rng(
    input logic [AWD-1:0] a
  );
    return (a & MASK) == SCR1_MEM_BASE;
  endfunction

  assign req_idx = imem_addr[AW+1:2];
  assign req_err = ~in_rng(imem_addr)
                 | (imem_cmd != CMD_RD)
                 | (imem_addr[1:0] != 2'b00);

  assign imem_req_ack = rst_n & ~ld_en
                      & (state == ST_IDLE
                       | state == ST_RESP);
  assign accept = imem_req & imem_req_ack;

  // zero-wait accepts read the RAM straight from the request
  assign rsp_idx = accept ? req_idx : idx_r;
  assign rsp_err = accept ? req_err : err_r;

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) state_nx = WS0 ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt <= 4'd1) state_nx = ST_RESP;
      end
      ST_RESP: begin
        if (accept) state_nx = WS0 ? ST_RESP : ST_WAIT;
        else        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      idx_r      <= '0;
      err_r      <= 1'b0;
      imem_rdata <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cnt   <= WS;
        idx_r <= req_idx;
        err_r <= req_err;
      end else if (state == ST_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (state_nx == ST_RESP) begin
        imem_rdata <= rsp_err ? '0 : mem[rsp_idx];
      end else if (state == ST_RESP) begin
        imem_rdata <= '0;
      end
    end
  end

  assign imem_resp = (state != ST_RESP) ? RESP_NOTRDY
                   : err_r ? RESP_RDY_ER
                   : RESP_RDY_OK;

  assign ld_ok = ld_en & in_rng(ld_addr)
               & (ld_addr[1:0] == 2'b00);

  // RAM is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (ld_ok) mem[ld_addr[AW+1:2]] <= ld_data;
  end

`ifdef SCR1_TRGT_SIMULATION
  a_no_x_req: assert property (
    @(posedge clk) disable iff (!rst_n)
    imem_req |-> !$isunknown({imem_addr, imem_cmd})
  );
  a_resp_enc: assert property (
    @(posedge clk) disable iff (!rst_n)
    imem_resp != 2'b11
  );
  a_resp_src: assert property (
    @(posedge clk) disable iff (!rst_n)
    (imem_resp != RESP_NOTRDY) |->
      $past(accept) || $past(state == ST_WAIT)
  );
`endif

endmodule

// File: tb/tb_scr1_imem_responder.sv
// Bench for scr1_imem_responder: three wait-state variants
// against a transaction-level reference model.
`timescale 1ns/1ps

module tb_scr1_imem_responder;

  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam int          WORDS = 1024;
  localparam logic [1:0]  R_NR  = 2'b00;
  localparam logic [1:0]  R_OK  = 2'b01;
  localparam logic [1:0]  R_ER  = 2'b10;
  localparam logic        C_RD  = 1'b0;
  localparam logic        C_WR  = 1'b1;

  function automatic int ws_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 0 : 3;
  endfunction

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req   [3];
  logic        cmd   [3];
  logic [31:0] addr  [3];
  logic        ack   [3];
  logic [1:0]  resp  [3];
  logic [31:0] rdata [3];
  logic        ld_en = 1'b0;
  logic [31:0] ld_addr = '0;
  logic [31:0] ld_data = '0;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    scr1_imem_responder #(
      .SCR1_MEM_BASE   (BASE),
      .SCR1_MEM_WORDS  (WORDS),
      .SCR1_WAIT_STATES(ws_of(g))
    ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req_ack(ack[g]),
      .imem_req    (req[g]),
      .imem_cmd    (cmd[g]),
      .imem_addr   (addr[g]),
      .imem_rdata  (rdata[g]),
      .imem_resp   (resp[g]),
      .ld_en       (ld_en),
      .ld_addr     (ld_addr),
      .ld_data     (ld_data)
    );
  end

  task automatic chk(
    input string       nm,
    input int          d,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d t=%0t got %h expected %h",
               nm, d, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mm [WORDS];
  bit          p_vld [3];
  bit          p_err [3];
  int          p_cyc [3];
  int          p_idx [3];
  bit          r_vld [3];
  bit          r_err [3];
  logic [31:0] r_data [3];
  int          cyc = 0;

  function automatic bit legal(input logic [31:0] a, input logic c);
    return (a >= BASE) && (a < BASE + 32'(WORDS * 4))
        && (a % 4 == 0) && (c == C_RD);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) / 4) % WORDS;
  endfunction

  initial begin
    bit acc;
    bit e;
    int ix;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int d = 0; d < 3; d++) begin
          p_vld[d] = 0;
          r_vld[d] = 0;
        end
      end else begin
        cyc++;
        for (int d = 0; d < 3; d++) begin
          acc = req[d] && !ld_en && !p_vld[d];
          r_vld[d] = 0;
          if (p_vld[d] && p_cyc[d] == cyc) begin
            r_vld[d]  = 1;
            r_err[d]  = p_err[d];
            r_data[d] = mm[p_idx[d]];
            p_vld[d]  = 0;
          end
          if (acc) begin
            e  = !legal(addr[d], cmd[d]);
            ix = widx(addr[d]);
            if (ws_of(d) == 0) begin
              r_vld[d]  = 1;
              r_err[d]  = e;
              r_data[d] = mm[ix];
            end else begin
              p_vld[d] = 1;
              p_cyc[d] = cyc + ws_of(d);
              p_err[d] = e;
              p_idx[d] = ix;
            end
          end
        end
        if (ld_en && legal(ld_addr, C_RD)) mm[widx(ld_addr)] = ld_data;
      end
    end
  end

  // every cycle, every DUT against the model
  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        chk("m_ack", d, 32'(ack[d]),
            32'(rst_n && !ld_en && !p_vld[d]));
        chk("m_resp", d, 32'(resp[d]),
            32'(r_vld[d] ? (r_err[d] ? R_ER : R_OK) : R_NR));
        chk("m_rdata", d, rdata[d],
            (r_vld[d] && !r_err[d]) ? r_data[d] : 32'h0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_all();
    for (int d = 0; d < 3; d++) begin
      req[d]  = 1'b0;
      cmd[d]  = C_RD;
      addr[d] = '0;
    end
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] v);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = v;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic fetch(
    input  int          d,
    input  logic [31:0] a,
    input  logic        c,
    output logic [1:0]  r,
    output logic [31:0] q
  );
    req[d]  = 1'b1;
    addr[d] = a;
    cmd[d]  = c;
    @(negedge clk);
    chk("fetch_ack", d, 32'(ack[d]), 32'h1);
    tick();
    req[d] = 1'b0;
    repeat (ws_of(d)) tick();
    @(negedge clk);
    r = resp[d];
    q = rdata[d];
    tick();
  endtask

  function automatic logic [31:0] rand_addr();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return 32'h0002_0000 + 32'(4 * $urandom_range(0, 255));
    if (k == 1) return BASE + 32'(4 * $urandom_range(0, 63))
                            + 32'($urandom_range(1, 3));
    if (k == 2) return BASE + 32'hFFC;
    return BASE + 32'(4 * $urandom_range(0, 63));
  endfunction

  typedef struct {
    logic [31:0] a;
    logic        c;
    logic [1:0]  r;
    logic [31:0] q;
  } vec_t;

  vec_t tab [8];

  initial begin
    logic [1:0]  r;
    logic [31:0] q;
    logic [31:0] old_w;
    logic [31:0] new_w;

    tab[0] = '{32'h0002_0000, C_RD, R_ER, 32'h0};
    tab[1] = '{32'h0001_0010, C_RD, R_OK, 32'hDEADBEEF};
    tab[2] = '{32'h0001_0002, C_RD, R_ER, 32'h0};
    tab[3] = '{32'h0001_0FFC, C_RD, R_OK, 32'h12345678};
    tab[4] = '{32'h0001_0000, C_WR, R_ER, 32'h0};
    tab[5] = '{32'h0001_0010, C_RD, R_OK, 32'hDEADBEEF};
    tab[6] = '{32'h0000_FFFC, C_RD, R_ER, 32'h0};
    tab[7] = '{32'h0001_1000, C_RD, R_ER, 32'h0};

    idle_all();
    rst_n = 1'b0;
    repeat (3) tick();

    // reset state
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("rst_ack", d, 32'(ack[d]), 32'h0);
      chk("rst_resp", d, 32'(resp[d]), 32'(R_NR));
      chk("rst_rdata", d, rdata[d], 32'h0);
    end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("rel_ack", d, 32'(ack[d]), 32'h1);
      chk("rel_resp", d, 32'(resp[d]), 32'(R_NR));
    end
    tick();

    for (int i = 0; i < 64; i++) load(BASE + 32'(4 * i), $urandom);
    load(BASE + 32'hFFC, 32'h12345678);
    load(BASE + 32'h10, 32'hDEADBEEF);

    // one-wait-state fetch, cycle by cycle
    req[0]  = 1'b1;
    addr[0] = BASE + 32'h10;
    cmd[0]  = C_RD;
    @(negedge clk);
    chk("t2_ack", 0, 32'(ack[0]), 32'h1);
    tick();
    req[0] = 1'b0;
    @(negedge clk);
    chk("t2_wait_ack", 0, 32'(ack[0]), 32'h0);
    chk("t2_wait_resp", 0, 32'(resp[0]), 32'(R_NR));
    tick();
    @(negedge clk);
    chk("t2_resp", 0, 32'(resp[0]), 32'(R_OK));
    chk("t2_rdata", 0, rdata[0], 32'hDEADBEEF);
    tick();
    @(negedge clk);
    chk("t2_after", 0, 32'(resp[0]), 32'(R_NR));
    tick();

    // decode / error table on every latency variant
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 8; i++) begin
        fetch(d, tab[i].a, tab[i].c, r, q);
        chk("tab_resp", d, 32'(r), 32'(tab[i].r));
        chk("tab_rdata", d, q, tab[i].q);
      end
    end

    // zero-wait streaming
    req[1] = 1'b1;
    cmd[1] = C_RD;
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) addr[1] = BASE + 32'(4 * i);
      else req[1] = 1'b0;
      @(negedge clk);
      if (i < 16) chk("s_ack", 1, 32'(ack[1]), 32'h1);
      if (i > 0) begin
        chk("s_resp", 1, 32'(resp[1]), 32'(R_OK));
        chk("s_rdata", 1, rdata[1], mm[i-1]);
      end
      tick();
    end
    repeat (2) tick();

    // loader blocks accepts
    req[0]  = 1'b1;
    addr[0] = BASE;
    for (int i = 0; i < 4; i++) begin
      ld_en   = 1'b1;
      ld_addr = BASE + 32'(4 * (40 + i));
      ld_data = $urandom;
      @(negedge clk);
      for (int d = 0; d < 3; d++)
        chk("ld_ack", d, 32'(ack[d]), 32'h0);
      tick();
    end
    ld_en = 1'b0;
    @(negedge clk);
    chk("ld_rel_ack", 0, 32'(ack[0]), 32'h1);
    tick();
    req[0] = 1'b0;
    repeat (3) tick();

    // same-edge load and response read returns the old word
    old_w   = mm[8];
    new_w   = ~old_w;
    req[0]  = 1'b1;
    addr[0] = BASE + 32'h20;
    tick();
    req[0]  = 1'b0;
    ld_en   = 1'b1;
    ld_addr = BASE + 32'h20;
    ld_data = new_w;
    tick();
    ld_en = 1'b0;
    @(negedge clk);
    chk("same_resp", 0, 32'(resp[0]), 32'(R_OK));
    chk("same_old", 0, rdata[0], old_w);
    tick();
    fetch(0, BASE + 32'h20, C_RD, r, q);
    chk("same_new", 0, q, new_w);

    // reset while waiting
    req[2]  = 1'b1;
    addr[2] = BASE + 32'h30;
    tick();
    req[2] = 1'b0;
    tick();
    rst_n = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("rm_resp", 2, 32'(resp[2]), 32'(R_NR));
      tick();
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("rm_post", 2, 32'(resp[2]), 32'(R_NR));
      tick();
    end
    fetch(2, BASE + 32'h30, C_RD, r, q);
    chk("rm_fetch_resp", 2, 32'(r), 32'(R_OK));
    chk("rm_fetch_data", 2, q, mm[12]);

    // random traffic, model-checked each cycle
    repeat (500) begin
      for (int d = 0; d < 3; d++) begin
        req[d]  = 1'($urandom_range(0, 1));
        cmd[d]  = ($urandom_range(0, 9) == 0) ? C_WR : C_RD;
        addr[d] = rand_addr();
      end
      ld_en   = ($urandom_range(0, 9) == 0);
      ld_addr = rand_addr();
      ld_data = $urandom;
      tick();
    end
    idle_all();
    ld_en = 1'b0;
    repeat (6) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
